// File: rtl/signed_threshold_scanner.sv
// Signed threshold scanner: collects CHANNELS signed samples per frame and reports a hit mask and count.
// Define SIGNED_SCAN_PEAK_EN to build the frame peak tracker; without it out_peak is tied to 0.
module signed_threshold_scanner #(
    parameter int unsigned BITS     = 8,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [BITS:0]          in_data,
    input  logic signed [BITS:0]          threshold,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHANNELS-1:0]           out_mask,
    output logic [$clog2(CHANNELS+1)-1:0] out_count,
    output logic signed [BITS:0]          out_peak
);
    localparam int unsigned CW = $clog2(CHANNELS + 1);
    localparam int unsigned IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_next;
    logic signed [BITS:0] thr_q;
    logic signed [BITS:0] thr_eff;
    logic [CHANNELS-1:0]  mask_q;
    logic [CHANNELS-1:0]  mask_next;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_next;
    logic                 accept;
    logic                 first_beat;
    logic                 last_beat;
    logic                 hit;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: a frame ends on the last accepted beat, HOLD ends on the result handshake
    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (accept && last_beat) next_state = HOLD;
            HOLD:    if (out_ready)           next_state = COLLECT;
            default:                          next_state = COLLECT;
        endcase
    end

    // Beat datapath; beat 0 compares against the threshold being latched on that same beat
    always_comb begin
        accept     = in_valid & in_ready;
        first_beat = (idx == '0);
        last_beat  = (idx == LAST_IDX);
        thr_eff    = first_beat ? threshold : thr_q;
        hit        = (in_data > thr_eff);
        mask_next  = first_beat ? '0 : mask_q;
        mask_next[idx] = hit;
        count_next = (first_beat ? '0 : count_q) + CW'(hit);
        idx_next   = last_beat ? '0 : idx + IW'(1);
    end

    // Frame accumulation and registered result/handshake outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            idx       <= '0;
            thr_q     <= '0;
            mask_q    <= '0;
            count_q   <= '0;
            out_mask  <= '0;
            out_count <= '0;
        end else begin
            in_ready  <= (next_state == COLLECT);
            out_valid <= (next_state == HOLD);
            if (accept) begin
                idx     <= idx_next;
                mask_q  <= mask_next;
                count_q <= count_next;
                if (first_beat) begin
                    thr_q <= threshold;
                end
                if (last_beat) begin
                    out_mask  <= mask_next;
                    out_count <= count_next;
                end
            end
        end
    end

`ifdef SIGNED_SCAN_PEAK_EN
    logic signed [BITS:0] peak_q;
    logic signed [BITS:0] peak_next;

    // Running signed maximum, reloaded by the first sample of each frame
    always_comb begin
        peak_next = peak_q;
        if (first_beat || (in_data > peak_q)) begin
            peak_next = in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            peak_q   <= '0;
            out_peak <= '0;
        end else if (accept) begin
            peak_q <= peak_next;
            if (last_beat) begin
                out_peak <= peak_next;
            end
        end
    end
`else
    assign out_peak = '0;
`endif

endmodule

// File: doc/signed_threshold_scanner.md
# signed_threshold_scanner

Consumer side of the signed multi-channel threshold interface: accepts a frame of `CHANNELS` signed samples, one per beat, over a valid/ready stream. Compares each sample against a signed threshold latched at frame start. Returns a per-channel hit mask, a hit count and, optionally, the frame peak. Sits downstream of the channel-value producer, whose `[BITS:0]` signed samples and threshold it reads.

## Interface
- `BITS`, default 8: sample and threshold width is `BITS+1`, two's complement.
- `CHANNELS`, default 2: samples per frame; must be ≥1.
- `clk` input 1: the only clock; all state on rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data` holds a sample.
- `in_ready` output 1: scanner accepts a sample this cycle.
- `in_data` input `[BITS:0]` signed: sample for the current channel index.
- `threshold` input `[BITS:0]` signed: sampled on the first beat of each frame.
- `out_valid` output 1: frame result held on the `out_*` ports.
- `out_ready` input 1: downstream consumes the result.
- `out_mask` output `[CHANNELS-1:0]`: bit i set when channel i sample > threshold.
- `out_count` output `[$clog2(CHANNELS+1)-1:0]`: popcount of `out_mask`.
- `out_peak` output `[BITS:0]` signed: maximum sample of the frame.

## Operation
- FSM states:
  - COLLECT: `in_ready=1`, `out_valid=0`.
  - HOLD: `in_ready=0`, `out_valid=1`.
- Channel index `idx`, 0..CHANNELS-1, advances on each accepted beat (`in_valid & in_ready`). Sample k of a frame is channel k.
- On the beat with `idx==0`:
  - latch `threshold` into `thr_q`;
  - clear the mask and count;
  - load the peak with `in_data`.
- Hit rule on every beat: the sample is compared with `thr_q` (the threshold latched on beat 0). On beat 0 itself, the compare uses the threshold value being latched on that beat.
  - The compare is strictly greater-than and signed.
  - -1 > -2 is a hit; 255 vs -256 is a hit; equality is not a hit.
- Peak update on beats after beat 0: signed max.
- On the beat with `idx==CHANNELS-1`:
  - `idx` wraps to 0;
  - state moves to HOLD;
  - the `out_*` registers update with the final mask, count and peak.
- HOLD: the `out_*` ports are stable until `out_valid & out_ready`, then the state returns to COLLECT.
- A threshold change mid-frame is ignored until the next frame.
- `CHANNELS==1`: every beat is both first and last.
- Reset values: `in_ready=0` while `rstn` is low, then 1 from the first cycle after release. `out_valid=0`, `out_mask=0`, `out_count=0`, `out_peak=0`, `idx=0`, state COLLECT.
- Reset mid-frame discards the partial frame; no result is emitted.

## Timing
- `out_valid` rises one cycle after the last accepted beat.
- Minimum frame period is CHANNELS+1 cycles (CHANNELS beats plus one HOLD cycle with `out_ready=1`).
- No bypass:
  - `in_ready` stays 0 during HOLD, including the cycle in which `out_ready` completes the handshake.
  - `in_ready` returns to 1 on the following cycle.
- `in_valid` gaps stall `idx`. Beats need not be contiguous.
- `out_ready` may be held high permanently. `out_valid` never drops without a handshake.
- All outputs are registered. There is no combinational path from inputs to outputs except `in_ready`, which is a decode of state only.

## Configuration
- Macro: `SIGNED_SCAN_PEAK_EN`.
- Defined: peak register and signed max logic are built, and `out_peak` behaves as described.
- Undefined: the peak register is not built. `out_peak` is tied to 0 at all times and the port list is unchanged.
- Mask, count and handshake behaviour are identical in both builds.

## Test plan
- Reset then single frame (BITS=8, CHANNELS=2): threshold=10, samples 11, 10 → `out_mask=2'b01`, `out_count=1`, `out_peak=11`; `out_valid` rises one cycle after beat 2.
- Signed compare: threshold=-2, samples -1, -256 → `out_mask=2'b01`, `out_peak=-1`. Threshold=-256, samples 255, -255 → mask `2'b11`, count 2.
- Backpressure: `out_ready=0` for 5 cycles after `out_valid` → outputs stable, `in_ready=0` throughout. `in_ready` rises the cycle after the handshake. Next frame threshold=0, samples 0, 0 → mask 0, count 0.
- Threshold change mid-frame: threshold=100 on beat 0, 0 on beat 1, samples 50, 50 → mask 0.
- Reset mid-frame: assert `rstn=0` after beat 0 → no `out_valid`, all outputs 0. Fresh frame 5, -5 with threshold=0 → mask `2'b01`.
- Build without `SIGNED_SCAN_PEAK_EN`: repeat the first scenario → same mask and count, `out_peak=0`.
